// File: rtl/module_serial_sub_8bits_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave returns {borrow, difference}.
interface module_serial_sub_8bits_if #(
   parameter int WIDTH2 = 8
);
   logic              start_pi;
   logic [WIDTH2-1:0] a_pi;
   logic [WIDTH2-1:0] b_pi;
   logic              busy_po;
   logic              done_po;
   logic [WIDTH2:0]   result_po;

   modport master (
      output start_pi, a_pi, b_pi,
      input  busy_po, done_po, result_po
   );

   modport slave (
      input  start_pi, a_pi, b_pi,
      output busy_po, done_po, result_po
   );
endinterface

// File: rtl/module_serial_sub_8bits.sv
// Bit-serial subtractor: one full-subtractor cell, LSB first, ripple borrow.
// Result is {borrow, difference}, registered together with the done pulse.
module module_serial_sub_8bits #(
   parameter int WIDTH2 = 8
) (
   input  logic                     clk_pi,
   input  logic                     rst_n_pi,
   module_serial_sub_8bits_if.slave bus
);
   localparam int CW = (WIDTH2 > 2) ? $clog2(WIDTH2) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH2 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH2-1:0] a_sh, b_sh, diff_sh;
   logic [CW-1:0]     cnt_q;
   logic              borrow_q;
   logic              done_q;
   logic [WIDTH2:0]   res_q;
   logic              a, b, d, bo;

   always_comb begin
      a  = a_sh[0];
      b  = b_sh[0];
      d  = a ^ b ^ borrow_q;
      bo = (~a & b) | (~(a ^ b) & borrow_q);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start_pi) state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Operands latch only in IDLE, so starts during SHIFT/DONE are dropped
   always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
         a_sh     <= '0;
         b_sh     <= '0;
         diff_sh  <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
         res_q    <= '0;
      end else begin
         done_q <= (state_q == DONE);
         if (state_q == IDLE && bus.start_pi) begin
            a_sh     <= bus.a_pi;
            b_sh     <= bus.b_pi;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
         end
         if (state_q == SHIFT) begin
            a_sh     <= a_sh >> 1;
            b_sh     <= b_sh >> 1;
            diff_sh  <= {d, diff_sh[WIDTH2-1:1]};
            borrow_q <= bo;
            cnt_q    <= cnt_q + 1'b1;
         end
         if (state_q == DONE) res_q <= {borrow_q, diff_sh};
      end
   end

   assign bus.busy_po   = (state_q != IDLE);
   assign bus.done_po   = done_q;
   assign bus.result_po = res_q;
endmodule

// File: tb/tb_module_serial_sub_8bits.sv
// Scoreboard bench for the bit-serial subtractor.
// Stimulus pushes expected results and done cycles; a monitor pops on done.
module tb_module_serial_sub_8bits;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   passed = 0;
   logic prev_done = 1'b0;

   logic [8:0] exp_q[$];
   int         t_q[$];

   module_serial_sub_8bits_if #(.WIDTH2(8)) sif ();

   module_serial_sub_8bits #(.WIDTH2(8)) dut (
      .clk_pi  (clk),
      .rst_n_pi(rst_n),
      .bus     (sif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [8:0] model(input int a, input int b);
      int diff;
      diff = a - b;
      if (diff < 0) diff = diff + 256;
      return {(a < b) ? 1'b1 : 1'b0, diff[7:0]};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: compare whenever the DUT presents a done pulse
   always @(negedge clk) begin
      if (rst_n && sif.done_po) begin
         chk("done_single_cycle", prev_done, 0);
         chk("busy_at_done", sif.busy_po, 0);
         if (exp_q.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            chk("result", sif.result_po, exp_q.pop_front());
            chk("latency", cyc, t_q.pop_front());
         end
      end
      prev_done = rst_n && sif.done_po;
   end

   task automatic wait_idle();
      int g = 0;
      while (sif.busy_po && g < 50) begin
         @(posedge clk); #1;
         g++;
      end
      if (sif.busy_po) chk("idle_timeout", 1, 0);
   endtask

   task automatic issue(input int a, input int b);
      wait_idle();
      sif.start_pi = 1'b1;
      sif.a_pi = 8'(a);
      sif.b_pi = 8'(b);
      exp_q.push_back(model(a, b));
      t_q.push_back(cyc + 1 + 9);
      @(posedge clk); #1;
      sif.start_pi = 1'b0;
      sif.a_pi = 8'($urandom);
      sif.b_pi = 8'($urandom);
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      if (exp_q.size() != 0) begin
         chk("drain_timeout", int'(exp_q.size()), 0);
         exp_q.delete();
         t_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int n0;
      sif.start_pi = 1'b0;
      sif.a_pi = '0;
      sif.b_pi = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", sif.busy_po, 0);
      chk("rst_done", sif.done_po, 0);
      chk("rst_result", sif.result_po, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(200, 55);  drain();
      chk("t1_direct", sif.result_po, 9'h091);
      issue(55, 200);  drain();
      chk("t2_direct", sif.result_po, 9'h16F);
      issue(0, 1);     drain();
      issue(128, 128); drain();
      issue(255, 0);   drain();

      // Starts during SHIFT and DONE must be ignored
      issue(100, 30);
      n0 = cyc;
      while (cyc < n0 + 2) begin @(posedge clk); #1; end
      sif.start_pi = 1'b1; sif.a_pi = 8'd1; sif.b_pi = 8'd2;
      @(posedge clk); #1;
      sif.start_pi = 1'b0;
      while (cyc < n0 + 8) begin @(posedge clk); #1; end
      sif.start_pi = 1'b1; sif.a_pi = 8'd3; sif.b_pi = 8'd4;
      @(posedge clk); #1;
      sif.start_pi = 1'b0;
      drain();
      repeat (12) @(posedge clk);
      #1;

      // Start held high: back-to-back results ten cycles apart
      sif.start_pi = 1'b1; sif.a_pi = 8'd10; sif.b_pi = 8'd3;
      exp_q.push_back(9'h007); t_q.push_back(cyc + 1 + 9);
      exp_q.push_back(9'h1F9); t_q.push_back(cyc + 1 + 19);
      @(posedge clk); #1;
      sif.a_pi = 8'd3; sif.b_pi = 8'd10;
      repeat (10) @(posedge clk);
      #1;
      sif.start_pi = 1'b0;
      drain();

      // Reset during an operation aborts it
      issue(77, 11);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      t_q.delete();
      #1;
      chk("abort_busy", sif.busy_po, 0);
      chk("abort_done", sif.done_po, 0);
      chk("abort_result", sif.result_po, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;

      for (int i = 0; i < 1000; i++) begin
         issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
         if (exp_q.size() > 1) drain();
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
